// File: rtl/date_display_pkg.sv
// Shared constants for the DD.MM.CCYY seven-segment scanner: segment patterns,
// edit-field encodings and the slot-to-field mapping.
package date_display_pkg;

  localparam int NUM_DIGITS = 8;

  // Active-low gfedcba patterns for a common-anode display
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [2:0] {
    FIELD_NONE    = 3'd0,
    FIELD_DAY     = 3'd1,
    FIELD_MONTH   = 3'd2,
    FIELD_CENTURY = 3'd3,
    FIELD_YEAR    = 3'd4
  } field_e;

  // Slots pair up left to right as day, month, century, year
  function automatic field_e slotField(input logic [2:0] slot);
    case (slot)
      3'd7, 3'd6: return FIELD_DAY;
      3'd5, 3'd4: return FIELD_MONTH;
      3'd3, 3'd2: return FIELD_CENTURY;
      default:    return FIELD_YEAR;
    endcase
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low seven-segment decoder; codes above 9 show a
// dash so corrupted calendar digits are visible rather than misleading.
module bcd_to_seg7
  import date_display_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0: seg_o = SEG_0;
      4'd1: seg_o = SEG_1;
      4'd2: seg_o = SEG_2;
      4'd3: seg_o = SEG_3;
      4'd4: seg_o = SEG_4;
      4'd5: seg_o = SEG_5;
      4'd6: seg_o = SEG_6;
      4'd7: seg_o = SEG_7;
      4'd8: seg_o = SEG_8;
      4'd9: seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/date_display_scan.sv
// Eight-digit multiplexed DD.MM.CCYY driver: scans a per-frame snapshot of the
// calendar digits, blanks leading zeros, dashes bad BCD and blinks the edited field.
module date_display_scan
  import date_display_pkg::*;
#(
  parameter int REFRESH_DIV = 50_000,
  parameter int BLINK_DIV   = 12_500_000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic       clk_50MHz,
  input  logic       reset,
  input  logic [3:0] d_10s,
  input  logic [3:0] d_1s,
  input  logic [3:0] m_10s,
  input  logic [3:0] m_1s,
  input  logic [3:0] c_10s,
  input  logic [3:0] c_1s,
  input  logic [3:0] y_10s,
  input  logic [3:0] y_1s,
  input  logic [2:0] field_sel,
  input  logic       display_en,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_start
);

  localparam int PRE_W = $clog2(REFRESH_DIV);
  localparam int BLK_W = $clog2(BLINK_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

  logic [PRE_W-1:0] prescale_q, prescale_d;
  logic [2:0]       slotIdx_q, slotIdx_d;
  logic [BLK_W-1:0] blinkCnt_q, blinkCnt_d;
  logic             blinkOn_q, blinkOn_d;
  logic             first_q;
  logic [NUM_DIGITS-1:0][3:0] snap_q, snap_d;
  logic [NUM_DIGITS-1:0][3:0] liveDigits;
  logic [7:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             frameStart_q, frameStart_d;

  logic             slotEnd;
  logic             loadSnap;
  logic [3:0]       digit;
  logic [6:0]       segRaw;
  logic [2:0]       curField;
  logic             blinkHide;
  logic             leadZero;

  assign liveDigits = {d_10s, d_1s, m_10s, m_1s, c_10s, c_1s, y_10s, y_1s};

  // The snapshot reloads exactly when slot 0 hands over to slot 7, so a frame never tears
  assign slotEnd  = (prescale_q == PRE_LAST);
  assign loadSnap = first_q || (slotEnd && (slotIdx_q == 3'd0));

  assign digit    = snap_q[slotIdx_q];
  assign curField = slotField(slotIdx_q);

  bcd_to_seg7 uSegDecode (
    .bcd_i (digit),
    .seg_o (segRaw)
  );

  always_comb begin
    prescale_d   = slotEnd ? '0 : prescale_q + 1'b1;
    slotIdx_d    = slotEnd ? slotIdx_q - 3'd1 : slotIdx_q;
    blinkCnt_d   = (blinkCnt_q == BLK_LAST) ? '0 : blinkCnt_q + 1'b1;
    blinkOn_d    = (blinkCnt_q == BLK_LAST) ? ~blinkOn_q : blinkOn_q;
    snap_d       = loadSnap ? liveDigits : snap_q;
    frameStart_d = loadSnap;
  end

  assign blinkHide = !blinkOn_q && (field_sel == curField);
  assign leadZero  = BLANK_LZ && ((slotIdx_q == 3'd7) || (slotIdx_q == 3'd5)) && (digit == 4'd0);

  // Priority: display off, blink-off, bad digit (dash, dp kept), leading zero
  always_comb begin
    an_d  = ~(8'b1 << slotIdx_q);
    seg_d = segRaw;
    dp_d  = !((slotIdx_q == 3'd6) || (slotIdx_q == 3'd4));
    if (!display_en) begin
      an_d  = 8'hFF;
      seg_d = SEG_BLANK;
      dp_d  = 1'b1;
    end else if (blinkHide) begin
      seg_d = SEG_BLANK;
      dp_d  = 1'b1;
    end else if (digit > 4'd9) begin
      seg_d = SEG_DASH;
    end else if (leadZero) begin
      seg_d = SEG_BLANK;
      dp_d  = 1'b1;
    end
  end

  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      prescale_q   <= '0;
      slotIdx_q    <= 3'd7;
      blinkCnt_q   <= '0;
      blinkOn_q    <= 1'b1;
      first_q      <= 1'b1;
      snap_q       <= '0;
      an_q         <= 8'hFF;
      seg_q        <= SEG_BLANK;
      dp_q         <= 1'b1;
      frameStart_q <= 1'b0;
    end else begin
      prescale_q   <= prescale_d;
      slotIdx_q    <= slotIdx_d;
      blinkCnt_q   <= blinkCnt_d;
      blinkOn_q    <= blinkOn_d;
      first_q      <= 1'b0;
      snap_q       <= snap_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frameStart_q <= frameStart_d;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign frame_start = frameStart_q;

endmodule

// File: tb/tb_date_display_scan.sv
// Directed bench for date_display_scan: per-frame slot expectations are queued
// when the date is driven and popped as each slot appears on the display.
module tb_date_display_scan;

  logic       clk;
  logic       reset;
  logic [3:0] d_10s, d_1s, m_10s, m_1s, c_10s, c_1s, y_10s, y_1s;
  logic [2:0] field_sel;
  logic       display_en;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_start;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  typedef struct {
    string      tag;
    int         slot;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t sbQ[$];

  date_display_scan #(
    .REFRESH_DIV (4),
    .BLINK_DIV   (64),
    .BLANK_LZ    (1'b1)
  ) dut (
    .clk_50MHz   (clk),
    .reset       (reset),
    .d_10s       (d_10s),
    .d_1s        (d_1s),
    .m_10s       (m_10s),
    .m_1s        (m_1s),
    .c_10s       (c_10s),
    .c_1s        (c_1s),
    .y_10s       (y_10s),
    .y_1s        (y_1s),
    .field_sel   (field_sel),
    .display_en  (display_en),
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] digits);
    {d_10s, d_1s, m_10s, m_1s, c_10s, c_1s, y_10s, y_1s} = digits;
  endtask

  // Segment list is given leftmost slot first; dpBits[s] is the dp level for slot s
  task automatic pushFrame(input string tag, input logic [7:0][6:0] segs, input logic [7:0] dpBits);
    for (int s = 7; s >= 0; s--) begin
      exp_t e;
      logic [7:0] anExp;
      anExp = 8'hFF;
      anExp[s] = 1'b0;
      e.tag  = tag;
      e.slot = s;
      e.an   = anExp;
      e.seg  = segs[s];
      e.dp   = dpBits[s];
      sbQ.push_back(e);
    end
  endtask

  task automatic waitFrame();
    int n;
    n = 0;
    while (frame_start !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("frame_wait", {31'd0, frame_start}, 32'd1);
  endtask

  // Slot 7-j is sampled in the first cycle its output is shown; optionally y_1s
  // is changed after sample midSlot to prove the frame snapshot hides it
  task automatic scanFrame(input int midSlot, input logic [3:0] midY1s);
    waitFrame();
    for (int j = 0; j < 8; j++) begin
      exp_t e;
      @(posedge clk);
      @(negedge clk);
      if (j == 0) checkOutput("frame_start_width", {31'd0, frame_start}, 32'd0);
      e = sbQ.pop_front();
      checkOutput($sformatf("%s_s%0d_an", e.tag, e.slot), {24'd0, an}, {24'd0, e.an});
      checkOutput($sformatf("%s_s%0d_seg", e.tag, e.slot), {25'd0, seg}, {25'd0, e.seg});
      checkOutput($sformatf("%s_s%0d_dp", e.tag, e.slot), {31'd0, dp}, {31'd0, e.dp});
      if (j == midSlot) y_1s = midY1s;
      if (j < 7) repeat (3) @(posedge clk);
    end
  endtask

  initial begin
    logic [7:0][6:0] segs;

    reset      = 1'b1;
    field_sel  = 3'd0;
    display_en = 1'b1;
    applyStimulus(32'h2303_2024);
    repeat (3) @(negedge clk);
    checkOutput("reset_an", {24'd0, an}, 32'hFF);
    checkOutput("reset_seg", {25'd0, seg}, 32'h7F);
    checkOutput("reset_dp", {31'd0, dp}, 32'd1);
    checkOutput("reset_frame_start", {31'd0, frame_start}, 32'd0);
    reset = 1'b0;

    // 23.03.2024: month tens is zero and therefore blanked
    pushFrame("d230324", {7'h24, 7'h30, 7'h7F, 7'h30, 7'h24, 7'h40, 7'h24, 7'h19}, 8'hAF);
    scanFrame(-1, 4'h0);

    // 05.01.2024 with leading zeros; y_1s moves to 5 mid-frame without effect
    applyStimulus(32'h0501_2024);
    pushFrame("d050124", {7'h7F, 7'h12, 7'h7F, 7'h79, 7'h24, 7'h40, 7'h24, 7'h19}, 8'hAF);
    scanFrame(3, 4'h5);

    // Invalid day units digit shows a dash with dp kept; y_1s=5 now visible
    d_1s = 4'hC;
    pushFrame("dashC", {7'h7F, 7'h3F, 7'h7F, 7'h79, 7'h24, 7'h40, 7'h24, 7'h12}, 8'hAF);
    scanFrame(-1, 4'h0);

    // Reset asserted while slot 3 is being shown
    applyStimulus(32'h2303_2024);
    waitFrame();
    repeat (17) @(posedge clk);
    @(negedge clk);
    checkOutput("pre_reset_slot3_an", {24'd0, an}, 32'hF7);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_reset_an", {24'd0, an}, 32'hFF);
    checkOutput("async_reset_seg", {25'd0, seg}, 32'h7F);
    checkOutput("async_reset_dp", {31'd0, dp}, 32'd1);
    field_sel = 3'd4;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("restart_frame_start", {31'd0, frame_start}, 32'd1);
    checkOutput("restart_slot7_an", {24'd0, an}, 32'h7F);

    // Year field blinks: visible for frames 0-1, hidden for 2-3, visible again at 4
    for (int k = 0; k < 5; k++) begin
      segs = {7'h24, 7'h30, 7'h7F, 7'h30, 7'h24, 7'h40, 7'h24, 7'h19};
      if (k == 2 || k == 3) begin
        segs[1] = 7'h7F;
        segs[0] = 7'h7F;
      end
      pushFrame($sformatf("blink%0d", k), segs, 8'hAF);
      scanFrame(-1, 4'h0);
    end

    // Display disabled: anodes off next cycle, frame timing keeps running
    display_en = 1'b0;
    @(negedge clk);
    checkOutput("disable_an", {24'd0, an}, 32'hFF);
    checkOutput("disable_seg", {25'd0, seg}, 32'h7F);
    checkOutput("disable_dp", {31'd0, dp}, 32'd1);
    waitFrame();
    repeat (31) @(negedge clk);
    checkOutput("disabled_gap_frame_start", {31'd0, frame_start}, 32'd0);
    @(negedge clk);
    checkOutput("disabled_period_frame_start", {31'd0, frame_start}, 32'd1);
    checkOutput("disabled_period_an", {24'd0, an}, 32'hFF);
    display_en = 1'b1;
    @(negedge clk);
    checkOutput("reenable_slot7_an", {24'd0, an}, 32'h7F);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
